// File: rtl/pin_verifier.sv
// -----------------------------------------------------------------------------
// pin_verifier
//
// Multi-digit PIN check for one ATM card session. The card PIN is latched when
// the session starts. User digits are then shifted in one at a time, and a
// complete entry is compared against the latched copy. Each wrong attempt uses
// up one try. The card locks when no tries remain, and an entry that stalls for
// too long is aborted.
//
// Parameters
//   DIGIT_W    bits per PIN digit
//   PIN_LEN    digits per PIN (>= 1)
//   MAX_TRIES  failed attempts allowed before lockout (>= 1)
//   TIMEOUT    idle cycles in ENTRY before abort, 0 disables the timeout
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-high
//   start        in   card accepted, begin session (honoured only in IDLE)
//   cancel       in   card ejected / session ended, abort from any state
//   pin_card     in   card PIN, digit 0 in the MSBs
//   digit_valid  in   digit_in is valid this cycle
//   digit_in     in   user digit
//   clear        in   user restart of the current entry
//   pin_matched  out  PIN verified, held until cancel
//   pin_fail     out  one-cycle pulse per wrong attempt
//   locked       out  attempts exhausted, held until cancel
//   timeout      out  one-cycle pulse on inactivity abort
//   busy         out  high while in ENTRY or CHECK
//   tries_left   out  remaining attempts
// -----------------------------------------------------------------------------
module pin_verifier #(
    parameter int DIGIT_W   = 4,
    parameter int PIN_LEN   = 4,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           cancel,
    input  logic [DIGIT_W*PIN_LEN-1:0]     pin_card,
    input  logic                           digit_valid,
    input  logic [DIGIT_W-1:0]             digit_in,
    input  logic                           clear,
    output logic                           pin_matched,
    output logic                           pin_fail,
    output logic                           locked,
    output logic                           timeout,
    output logic                           busy,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

    localparam int ENTRY_W = DIGIT_W * PIN_LEN;
    localparam int CNT_W   = $clog2(PIN_LEN + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int IDLE_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]  LAST_DIGIT = CNT_W'(PIN_LEN - 1);
    localparam logic [TRY_W-1:0]  TRIES_INIT = TRY_W'(MAX_TRIES);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_MATCH,
        S_LOCKED
    } state_t;

    state_t               state, state_n;
    logic [ENTRY_W-1:0]   pin_latched, pin_latched_n;
    logic [ENTRY_W-1:0]   entry, entry_n;
    logic [CNT_W-1:0]     count, count_n;
    logic [IDLE_W-1:0]    idle_cnt, idle_cnt_n;
    logic [TRY_W-1:0]     tries_n;
    logic                 matched_n, fail_n, locked_n, timeout_n, busy_n;

    // Next-state and next-output logic. Every register has a next value
    // computed here, so the outputs below are plain flops with no decoding
    // after the clock edge. cancel overrides whatever the current state
    // wants to do.
    always_comb begin
        state_n       = state;
        pin_latched_n = pin_latched;
        entry_n       = entry;
        count_n       = count;
        idle_cnt_n    = idle_cnt;
        tries_n       = tries_left;
        matched_n     = pin_matched;
        locked_n      = locked;
        fail_n        = 1'b0;
        timeout_n     = 1'b0;

        if (cancel) begin
            state_n    = S_IDLE;
            entry_n    = '0;
            count_n    = '0;
            idle_cnt_n = '0;
            tries_n    = '0;
            matched_n  = 1'b0;
            locked_n   = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        pin_latched_n = pin_card;
                        tries_n       = TRIES_INIT;
                        entry_n       = '0;
                        count_n       = '0;
                        idle_cnt_n    = '0;
                        state_n       = S_ENTRY;
                    end
                end

                S_ENTRY: begin
                    if (clear) begin
                        entry_n    = '0;
                        count_n    = '0;
                        idle_cnt_n = '0;
                    end else if (digit_valid) begin
                        // The first digit keyed ends up in the MSBs after
                        // PIN_LEN shifts, matching the pin_card layout.
                        entry_n    = (entry << DIGIT_W) | ENTRY_W'(digit_in);
                        count_n    = count + CNT_W'(1);
                        idle_cnt_n = '0;
                        if (count == LAST_DIGIT) begin
                            state_n = S_CHECK;
                        end
                    end else if (TIMEOUT != 0) begin
                        // The counter holds the number of idle cycles already
                        // seen, so the cycle that makes it TIMEOUT aborts.
                        if (idle_cnt == IDLE_LAST) begin
                            timeout_n  = 1'b1;
                            entry_n    = '0;
                            count_n    = '0;
                            idle_cnt_n = '0;
                            state_n    = S_IDLE;
                        end else begin
                            idle_cnt_n = idle_cnt + IDLE_W'(1);
                        end
                    end
                end

                S_CHECK: begin
                    entry_n    = '0;
                    count_n    = '0;
                    idle_cnt_n = '0;
                    if (entry == pin_latched) begin
                        matched_n = 1'b1;
                        state_n   = S_MATCH;
                    end else if (tries_left <= TRY_W'(1)) begin
                        // The last try is used up: lockout replaces the
                        // pin_fail pulse.
                        tries_n  = '0;
                        locked_n = 1'b1;
                        state_n  = S_LOCKED;
                    end else begin
                        tries_n = tries_left - TRY_W'(1);
                        fail_n  = 1'b1;
                        state_n = S_ENTRY;
                    end
                end

                S_MATCH, S_LOCKED: begin
                end

                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        busy_n = (state_n == S_ENTRY) || (state_n == S_CHECK);
    end

    // State and output registers. Reset discards the latched PIN and the
    // remaining tries, so a new session always starts from start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pin_latched <= '0;
            entry       <= '0;
            count       <= '0;
            idle_cnt    <= '0;
            tries_left  <= '0;
            pin_matched <= 1'b0;
            pin_fail    <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            pin_latched <= pin_latched_n;
            entry       <= entry_n;
            count       <= count_n;
            idle_cnt    <= idle_cnt_n;
            tries_left  <= tries_n;
            pin_matched <= matched_n;
            pin_fail    <= fail_n;
            locked      <= locked_n;
            timeout     <= timeout_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_pin_verifier.sv
// -----------------------------------------------------------------------------
// tb_pin_verifier
//
// Directed bench for pin_verifier with TIMEOUT shortened to 8 cycles. Most
// scenarios are one-cycle vectors in a table, each holding the inputs for one
// clock and the expected registered outputs after that edge. Asynchronous
// reset during CHECK and the inactivity timeout are written out by hand.
// -----------------------------------------------------------------------------
module tb_pin_verifier;

    localparam logic [15:0] CARD = 16'h1234;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cancel;
    logic [15:0] pin_card;
    logic        digit_valid;
    logic [3:0]  digit_in;
    logic        clear;
    logic        pin_matched;
    logic        pin_fail;
    logic        locked;
    logic        timeout;
    logic        busy;
    logic [1:0]  tries_left;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        start;
        logic        cancel;
        logic        dv;
        logic [3:0]  din;
        logic        clr;
        logic [15:0] card;
        logic        m;
        logic        f;
        logic        l;
        logic        t;
        logic        b;
        logic [1:0]  tries;
    } vec_t;

    vec_t vecs[$];

    pin_verifier #(
        .DIGIT_W   (4),
        .PIN_LEN   (4),
        .MAX_TRIES (3),
        .TIMEOUT   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cancel      (cancel),
        .pin_card    (pin_card),
        .digit_valid (digit_valid),
        .digit_in    (digit_in),
        .clear       (clear),
        .pin_matched (pin_matched),
        .pin_fail    (pin_fail),
        .locked      (locked),
        .timeout     (timeout),
        .busy        (busy),
        .tries_left  (tries_left)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the run stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired, simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cmp(input string name, input string field, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s.%s got %0d expected %0d", name, field, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic m, input logic f, input logic l,
                               input logic t, input logic b, input logic [1:0] tr,
                               input bit chk_tries);
        cmp(name, "pin_matched", int'(pin_matched), int'(m));
        cmp(name, "pin_fail",    int'(pin_fail),    int'(f));
        cmp(name, "locked",      int'(locked),      int'(l));
        cmp(name, "timeout",     int'(timeout),     int'(t));
        cmp(name, "busy",        int'(busy),        int'(b));
        if (chk_tries) cmp(name, "tries_left", int'(tries_left), int'(tr));
    endtask

    // Drive one cycle of inputs at the falling edge, and return 1 ns after
    // the following rising edge, when the registered outputs are stable.
    task automatic applyStimulus(input logic s, input logic c, input logic v,
                                 input logic [3:0] d, input logic cl, input logic [15:0] cd);
        @(negedge clk);
        start       = s;
        cancel      = c;
        digit_valid = v;
        digit_in    = d;
        clear       = cl;
        pin_card    = cd;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic s, input logic c, input logic v,
                        input logic [3:0] d, input logic cl,
                        input logic m, input logic f, input logic l, input logic t,
                        input logic b, input logic [1:0] tr, input bit chk_tries);
        applyStimulus(s, c, v, d, cl, CARD);
        checkOutput(name, m, f, l, t, b, tr, chk_tries);
    endtask

    task automatic addVec(input string n, input logic s, input logic c, input logic v,
                          input logic [3:0] d, input logic cl, input logic [15:0] cd,
                          input logic m, input logic f, input logic l, input logic t,
                          input logic b, input logic [1:0] tr);
        vec_t tmp;
        tmp.name = n;  tmp.start = s; tmp.cancel = c; tmp.dv = v; tmp.din = d;
        tmp.clr = cl;  tmp.card = cd; tmp.m = m; tmp.f = f; tmp.l = l;
        tmp.t = t;     tmp.b = b;     tmp.tries = tr;
        vecs.push_back(tmp);
    endtask

    initial begin
        // Table columns: name, start, cancel, dv, din, clr, card,
        // then the expected matched, fail, locked, timeout, busy, tries.

        // Correct PIN first time, then start in MATCH is ignored.
        addVec("t1_start",  1,0,0,0,0,CARD, 0,0,0,0,1,3);
        addVec("t1_k1",     0,0,1,1,0,CARD, 0,0,0,0,1,3);
        addVec("t1_k2",     0,0,1,2,0,CARD, 0,0,0,0,1,3);
        addVec("t1_k3",     0,0,1,3,0,CARD, 0,0,0,0,1,3);
        addVec("t1_k4",     0,0,1,4,0,CARD, 0,0,0,0,1,3);
        addVec("t1_check",  0,0,0,0,0,CARD, 1,0,0,0,0,3);
        addVec("t1_hold",   0,0,0,0,0,CARD, 1,0,0,0,0,3);
        addVec("t1_start2", 1,0,0,0,0,CARD, 1,0,0,0,0,3);
        addVec("t1_cancel", 0,1,0,0,0,CARD, 0,0,0,0,0,0);

        // One wrong attempt, then correct. A start during ENTRY is ignored.
        addVec("t2_start",  1,0,0,0,0,CARD, 0,0,0,0,1,3);
        addVec("t2_k1",     0,0,1,1,0,CARD, 0,0,0,0,1,3);
        addVec("t2_k2",     0,0,1,2,0,CARD, 0,0,0,0,1,3);
        addVec("t2_k3",     0,0,1,3,0,CARD, 0,0,0,0,1,3);
        addVec("t2_k5",     0,0,1,5,0,CARD, 0,0,0,0,1,3);
        addVec("t2_fail",   0,0,0,0,0,CARD, 0,1,0,0,1,2);
        addVec("t2_pulse",  0,0,0,0,0,CARD, 0,0,0,0,1,2);
        addVec("t2_r1",     0,0,1,1,0,CARD, 0,0,0,0,1,2);
        addVec("t2_r2",     0,0,1,2,0,CARD, 0,0,0,0,1,2);
        addVec("t2_start_ign", 1,0,0,0,0,16'h9999, 0,0,0,0,1,2);
        addVec("t2_r3",     0,0,1,3,0,CARD, 0,0,0,0,1,2);
        addVec("t2_r4",     0,0,1,4,0,CARD, 0,0,0,0,1,2);
        addVec("t2_match",  0,0,0,0,0,CARD, 1,0,0,0,0,2);
        addVec("t2_cancel", 0,1,0,0,0,CARD, 0,0,0,0,0,0);

        // Three wrong attempts lock the card. Digits afterwards are ignored.
        addVec("t3_start",  1,0,0,0,0,CARD, 0,0,0,0,1,3);
        addVec("t3_a1",     0,0,1,1,0,CARD, 0,0,0,0,1,3);
        addVec("t3_a2",     0,0,1,1,0,CARD, 0,0,0,0,1,3);
        addVec("t3_a3",     0,0,1,1,0,CARD, 0,0,0,0,1,3);
        addVec("t3_a4",     0,0,1,1,0,CARD, 0,0,0,0,1,3);
        addVec("t3_fail1",  0,0,0,0,0,CARD, 0,1,0,0,1,2);
        addVec("t3_b1",     0,0,1,2,0,CARD, 0,0,0,0,1,2);
        addVec("t3_b2",     0,0,1,2,0,CARD, 0,0,0,0,1,2);
        addVec("t3_b3",     0,0,1,2,0,CARD, 0,0,0,0,1,2);
        addVec("t3_b4",     0,0,1,2,0,CARD, 0,0,0,0,1,2);
        addVec("t3_fail2",  0,0,0,0,0,CARD, 0,1,0,0,1,1);
        addVec("t3_c1",     0,0,1,3,0,CARD, 0,0,0,0,1,1);
        addVec("t3_c2",     0,0,1,3,0,CARD, 0,0,0,0,1,1);
        addVec("t3_c3",     0,0,1,3,0,CARD, 0,0,0,0,1,1);
        addVec("t3_c4",     0,0,1,3,0,CARD, 0,0,0,0,1,1);
        addVec("t3_lock",   0,0,0,0,0,CARD, 0,0,1,0,0,0);
        addVec("t3_ign1",   0,0,1,1,0,CARD, 0,0,1,0,0,0);
        addVec("t3_ign2",   0,0,1,2,0,CARD, 0,0,1,0,0,0);
        addVec("t3_ign3",   0,0,1,3,0,CARD, 0,0,1,0,0,0);
        addVec("t3_ign4",   0,0,1,4,0,CARD, 0,0,1,0,0,0);
        addVec("t3_ign5",   0,0,0,0,0,CARD, 0,0,1,0,0,0);
        addVec("t3_ignst",  1,0,0,0,0,CARD, 0,0,1,0,0,0);
        addVec("t3_cancel", 0,1,0,0,0,CARD, 0,0,0,0,0,0);

        // clear beats digit_valid. pin_card changes after start are ignored.
        addVec("t4_start",  1,0,0,0,0,CARD, 0,0,0,0,1,3);
        addVec("t4_k1",     0,0,1,1,0,16'hFFFF, 0,0,0,0,1,3);
        addVec("t4_k2",     0,0,1,2,0,16'hFFFF, 0,0,0,0,1,3);
        addVec("t4_clr9",   0,0,1,9,1,16'hFFFF, 0,0,0,0,1,3);
        addVec("t4_k1b",    0,0,1,1,0,16'hFFFF, 0,0,0,0,1,3);
        addVec("t4_k2b",    0,0,1,2,0,16'hFFFF, 0,0,0,0,1,3);
        addVec("t4_k3b",    0,0,1,3,0,16'hFFFF, 0,0,0,0,1,3);
        addVec("t4_k4b",    0,0,1,4,0,16'hFFFF, 0,0,0,0,1,3);
        addVec("t4_match",  0,0,0,0,0,16'hFFFF, 1,0,0,0,0,3);
        addVec("t4_cancel", 0,1,0,0,0,CARD, 0,0,0,0,0,0);

        // cancel during ENTRY, which also beats a simultaneous digit, then a
        // clean restart.
        addVec("t6_start",  1,0,0,0,0,CARD, 0,0,0,0,1,3);
        addVec("t6_k1",     0,0,1,1,0,CARD, 0,0,0,0,1,3);
        addVec("t6_k2",     0,0,1,2,0,CARD, 0,0,0,0,1,3);
        addVec("t6_cancel", 0,1,1,3,0,CARD, 0,0,0,0,0,0);
        addVec("t6_idle",   0,0,1,4,0,CARD, 0,0,0,0,0,0);
        addVec("t6_restart",1,0,0,0,0,CARD, 0,0,0,0,1,3);
        addVec("t6_k1b",    0,0,1,1,0,CARD, 0,0,0,0,1,3);
        addVec("t6_k2b",    0,0,1,2,0,CARD, 0,0,0,0,1,3);
        addVec("t6_k3b",    0,0,1,3,0,CARD, 0,0,0,0,1,3);
        addVec("t6_k4b",    0,0,1,4,0,CARD, 0,0,0,0,1,3);
        addVec("t6_match",  0,0,0,0,0,CARD, 1,0,0,0,0,3);
        addVec("t6_cancel2",0,1,0,0,0,CARD, 0,0,0,0,0,0);

        // Reset, then check the reset state while rst is still held.
        rst = 1'b1; start = 1'b0; cancel = 1'b0; digit_valid = 1'b0;
        digit_in = 4'd0; clear = 1'b0; pin_card = CARD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset", 0,0,0,0,0,0, 1'b1);
        rst = 1'b0;

        $display("[TB] running %0d table vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].start, vecs[i].cancel, vecs[i].dv, vecs[i].din,
                          vecs[i].clr, vecs[i].card);
            checkOutput(vecs[i].name, vecs[i].m, vecs[i].f, vecs[i].l, vecs[i].t,
                        vecs[i].b, vecs[i].tries, 1'b1);
        end

        // Asynchronous reset while the FSM is in CHECK.
        step("r_start", 1,0,0,0,0, 0,0,0,0,1,3, 1'b1);
        step("r_k1",    0,0,1,1,0, 0,0,0,0,1,3, 1'b1);
        step("r_k2",    0,0,1,2,0, 0,0,0,0,1,3, 1'b1);
        step("r_k3",    0,0,1,3,0, 0,0,0,0,1,3, 1'b1);
        step("r_k4",    0,0,1,4,0, 0,0,0,0,1,3, 1'b1);
        @(negedge clk);
        start = 1'b0; digit_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("r_async", 0,0,0,0,0,0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("r_held", 0,0,0,0,0,0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        step("r_idle",    0,0,0,0,0, 0,0,0,0,0,0, 1'b1);
        step("r_restart", 1,0,0,0,0, 0,0,0,0,1,3, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step("r_key", 0,0,1,4'(k),0, 0,0,0,0,1,3, 1'b1);
        end
        step("r_match",   0,0,0,0,0, 1,0,0,0,0,3, 1'b1);
        step("r_cancel",  0,1,0,0,0, 0,0,0,0,0,0, 1'b1);

        // Inactivity timeout. A digit restarts the idle count, so 5 idle
        // cycles before it must not add to the 8 that follow.
        step("to_start", 1,0,0,0,0, 0,0,0,0,1,3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step("to_pre", 0,0,0,0,0, 0,0,0,0,1,3, 1'b1);
        end
        step("to_k1", 0,0,1,1,0, 0,0,0,0,1,3, 1'b1);
        for (int k = 0; k < 7; k++) begin
            step("to_wait", 0,0,0,0,0, 0,0,0,0,1,3, 1'b1);
        end
        step("to_fire",  0,0,0,0,0, 0,0,0,1,0,0, 1'b0);
        step("to_pulse", 0,0,0,0,0, 0,0,0,0,0,0, 1'b0);
        step("to_restart", 1,0,0,0,0, 0,0,0,0,1,3, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step("to_key", 0,0,1,4'(k),0, 0,0,0,0,1,3, 1'b1);
        end
        step("to_match",  0,0,0,0,0, 1,0,0,0,0,3, 1'b1);
        step("to_cancel", 0,1,0,0,0, 0,0,0,0,0,0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
